vmem_fill: RTL and testbench
============================

# vmem_fill

Memory-mapped rectangle-fill engine that sits directly upstream of `vmem` on its write port. The CPU programs origin, size and colour over the data bus, then starts the engine. It writes one 3-bit pixel per cycle into `vmem`, merging its writes with ordinary CPU stores to `vmem`. This offloads screen clears and solid-box drawing that would otherwise cost one store instruction per pixel.

## Interface
Parameters:
- `SCREEN_W`, 240, visible width; pixels with x ≥ SCREEN_W are suppressed.
- `SCREEN_H`, 240, visible height; pixels with y ≥ SCREEN_H are suppressed.

Ports:
- `clk_i` in 1: single clock for the whole block.
- `rst_ni` in 1: asynchronous, active-low reset.
- `we_i` in 1: register write strobe, already decoded for this block.
- `addr_i` in 4: register byte offset.
- `wdata_i` in 32: register write data.
- `rdata_o` out 32: register read data, registered.
- `cpu_we_i` in 1: CPU store to `vmem`.
- `cpu_addr_i` in 16: CPU store address, `{y,x}`.
- `cpu_wdata_i` in 3: CPU store colour.
- `vmem_we_o` out 1: merged write strobe to `vmem`.
- `vmem_addr_o` out 16: merged write address.
- `vmem_wdata_o` out 3: merged write colour.
- `busy_o` out 1: engine is running.

## Operation
Registers:
- 0x0 CTRL.
  - Write: bit0 = START, bit1 = ABORT, bit2 = CLR_DONE.
  - Read: `{29'b0, done, 1'b0, busy}`.
- 0x4 ORG: `{y0[15:8], x0[7:0]}`.
- 0x8 SIZE: `{h[15:8], w[7:0]}`.
- 0xC COLOR: bits [2:0].
- Writes to ORG, SIZE and COLOR are ignored while busy. Reads of ORG, SIZE and COLOR return the stored values zero-extended.

FSM has two states, IDLE and RUN.
- IDLE → RUN on a START write when w ≠ 0 and h ≠ 0. On entry the scan counters load x = x0, y = y0, col = 0, row = 0, and done is cleared.
- IDLE → IDLE with done set on a START write when w = 0 or h = 0. No pixel writes occur.
- START while in RUN is ignored.
- In RUN, each non-stalled cycle issues the pixel (x,y) and advances the scan:
  - col increments; x = x0 + col.
  - When col reaches w−1, col wraps to 0 and row increments.
- RUN → IDLE with done set after the pixel at row = h−1, col = w−1 has been issued.
- ABORT in RUN → IDLE on the next edge. done stays 0, and the pixel in flight that cycle is still written. ABORT takes precedence over START in the same write.
- CLR_DONE clears done. If CLR_DONE is written in the same cycle that done is set, set wins.

Arithmetic:
- x and y are computed 9 bits wide (x0 + col), so coordinates never wrap at 256.
- A pixel is suppressed (no strobe) when x ≥ SCREEN_W or y ≥ SCREEN_H. A suppressed pixel still consumes its cycle.
- `vmem_addr_o` = `{y[7:0], x[7:0]}`.

Arbitration:
- `cpu_we_i` has absolute priority.
- When it is high, the outputs carry the CPU store and the engine holds its pixel; the engine does not advance that cycle.
- Otherwise the outputs carry the engine pixel, with the strobe = RUN && !suppressed.

## Timing
- Reset values: FSM = IDLE; done = 0; all registers = 0; `rdata_o` = 0; `busy_o` = 0.
- In reset, the `vmem` outputs pass the CPU path through combinationally.
- A START write in cycle N gives `busy_o` = 1 and the first engine strobe in cycle N+1.
- With no stalls, the last pixel is issued in cycle N+w·h. `busy_o` = 0 and done = 1 in cycle N+w·h+1.
- Each cycle with `cpu_we_i` = 1 during RUN adds exactly one cycle.
- `rdata_o` is valid one cycle after `addr_i` is presented, matching the other bus slaves.
- An asynchronous reset during RUN stops the engine immediately. No further engine strobes occur.
- The `vmem_*` outputs are combinational from the engine registers and the `cpu_*` inputs; they have no added latency.

## Structure
- Package `vmem_fill_pkg` holds:
  - register offsets `REG_CTRL`, `REG_ORG`, `REG_SIZE`, `REG_COLOR`;
  - CTRL bit indices;
  - the state typedef {IDLE, RUN}.
- Sub-module `fill_scan` holds the col/row counters, the x/y adders, the last-pixel flag and the suppression compare. Its inputs are load, advance, x0, y0, w and h.
- Register file, FSM and arbitration mux live in the top module.

## Test plan
- ORG=0x0A05, SIZE=0x0302, COLOR=5, START:
  - exactly 6 strobes, at addresses 0x0A05, 0x0A06, 0x0B05, 0x0B06, 0x0C05, 0x0C06, all with data 5;
  - busy for 6 cycles, then CTRL reads 0b100.
- ORG=0x00EE (x0=238), SIZE=0x0104: strobes only at x=238 and x=239. busy lasts 4 cycles, and no strobe occurs at x=0 or x=1.
- `cpu_we_i` pulsed on cycles 2 and 3 of an 8-pixel fill:
  - CPU writes appear unchanged on the outputs;
  - engine pixels are neither lost nor duplicated;
  - done arrives 2 cycles late.
- SIZE=0x0000, START: no strobes; done = 1 one cycle later; busy never asserts.
- ABORT written on the 3rd cycle of a 100-pixel fill:
  - busy drops the next cycle;
  - 3 strobes total;
  - done = 0.
- `rst_ni` asserted mid-fill: busy, done, `rdata_o` and the engine strobe are all 0 immediately. A subsequent START runs a full fill correctly.

Source files
------------

// File: rtl/vmem_fill_pkg.sv
// Shared definitions for the vmem rectangle-fill engine.
// Holds the register byte offsets, the CTRL write bit positions and the FSM state type.
package vmem_fill_pkg;

    localparam logic [3:0] REG_CTRL  = 4'h0;
    localparam logic [3:0] REG_ORG   = 4'h4;
    localparam logic [3:0] REG_SIZE  = 4'h8;
    localparam logic [3:0] REG_COLOR = 4'hC;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_ABORT    = 1;
    localparam int unsigned CTRL_CLR_DONE = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/fill_scan.sv
// Raster scan generator for the fill engine.
// Walks col/row over a w x h rectangle and produces the current pixel coordinate.
//   load_i     : restart the scan at col = 0, row = 0
//   advance_i  : step to the next pixel (row-major)
//   x0_i, y0_i : rectangle origin
//   w_i, h_i   : rectangle size (both non-zero while scanning)
//   x_o, y_o   : 9-bit pixel coordinate, origin + offset, never wraps at 256
//   last_o     : current pixel is the final one of the rectangle
//   suppress_o : current pixel lies outside the visible screen
module fill_scan
    import vmem_fill_pkg::*;
#(
    parameter int unsigned SCREEN_W = 240,
    parameter int unsigned SCREEN_H = 240
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       advance_i,
    input  logic [7:0] x0_i,
    input  logic [7:0] y0_i,
    input  logic [7:0] w_i,
    input  logic [7:0] h_i,
    output logic [8:0] x_o,
    output logic [8:0] y_o,
    output logic       last_o,
    output logic       suppress_o
);

    logic [7:0] col_q, col_d;
    logic [7:0] row_q, row_d;
    logic       col_end;

    assign col_end = (col_q == w_i - 8'd1);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (load_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign x_o        = {1'b0, x0_i} + {1'b0, col_q};
    assign y_o        = {1'b0, y0_i} + {1'b0, row_q};
    assign last_o     = col_end && (row_q == h_i - 8'd1);
    assign suppress_o = (32'(x_o) >= SCREEN_W) || (32'(y_o) >= SCREEN_H);

endmodule

// File: rtl/vmem_fill.sv
// Memory-mapped rectangle-fill engine placed in front of the vmem write port.
// The CPU programs ORG/SIZE/COLOR, writes START, and the engine emits one pixel per cycle,
// yielding to CPU stores which always win the write port.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   we_i, addr_i, wdata_i   : register write port; rdata_o is the registered read data
//   cpu_we_i/addr_i/wdata_i : CPU store path into vmem
//   vmem_we_o/addr_o/wdata_o: merged write port to vmem (combinational)
//   busy_o                  : engine is running
module vmem_fill
    import vmem_fill_pkg::*;
#(
    parameter int unsigned SCREEN_W = 240,
    parameter int unsigned SCREEN_H = 240
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [2:0]  cpu_wdata_i,
    output logic        vmem_we_o,
    output logic [15:0] vmem_addr_o,
    output logic [2:0]  vmem_wdata_o,
    output logic        busy_o
);

    state_e      state_q, state_d;
    logic        done_q, done_d;
    logic [15:0] org_q, org_d;
    logic [15:0] size_q, size_d;
    logic [2:0]  color_q, color_d;
    logic [31:0] rdata_q, rdata_d;

    logic       busy, ctrl_wr, start, abort, clr_done, advance, load;
    logic [8:0] scan_x, scan_y;
    logic       scan_last, scan_suppress;
    logic       unused_bits;

    assign busy     = (state_q == RUN);
    assign ctrl_wr  = we_i && (addr_i == REG_CTRL);
    // ABORT masks START when both arrive in one write.
    assign start    = ctrl_wr && wdata_i[CTRL_START] && !wdata_i[CTRL_ABORT];
    assign abort    = ctrl_wr && wdata_i[CTRL_ABORT];
    assign clr_done = ctrl_wr && wdata_i[CTRL_CLR_DONE];
    // The engine freezes on its current pixel whenever the CPU owns the port.
    assign advance  = busy && !cpu_we_i;

    fill_scan #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_scan (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (load),
        .advance_i  (advance),
        .x0_i       (org_q[7:0]),
        .y0_i       (org_q[15:8]),
        .w_i        (size_q[7:0]),
        .h_i        (size_q[15:8]),
        .x_o        (scan_x),
        .y_o        (scan_y),
        .last_o     (scan_last),
        .suppress_o (scan_suppress)
    );

    // FSM and done flag; a done set later in this block overrides CLR_DONE.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        load    = 1'b0;
        if (clr_done) begin
            done_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_q[7:0] != 8'd0 && size_q[15:8] != 8'd0) begin
                        state_d = RUN;
                        load    = 1'b1;
                        done_d  = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (advance && scan_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Parameter registers are frozen while the engine runs.
    always_comb begin
        org_d   = org_q;
        size_d  = size_q;
        color_d = color_q;
        if (we_i && !busy) begin
            case (addr_i)
                REG_ORG:   org_d   = wdata_i[15:0];
                REG_SIZE:  size_d  = wdata_i[15:0];
                REG_COLOR: color_d = wdata_i[2:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        case (addr_i)
            REG_CTRL:  rdata_d = {29'b0, done_q, 1'b0, busy};
            REG_ORG:   rdata_d = {16'b0, org_q};
            REG_SIZE:  rdata_d = {16'b0, size_q};
            REG_COLOR: rdata_d = {29'b0, color_q};
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            org_q   <= '0;
            size_q  <= '0;
            color_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            org_q   <= org_d;
            size_q  <= size_d;
            color_q <= color_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        if (cpu_we_i) begin
            vmem_we_o    = 1'b1;
            vmem_addr_o  = cpu_addr_i;
            vmem_wdata_o = cpu_wdata_i;
        end else begin
            vmem_we_o    = busy && !scan_suppress;
            vmem_addr_o  = {scan_y[7:0], scan_x[7:0]};
            vmem_wdata_o = color_q;
        end
    end

    assign rdata_o     = rdata_q;
    assign busy_o      = busy;
    assign unused_bits = ^{wdata_i[31:16], scan_x[8], scan_y[8]};

endmodule

// File: tb/tb_vmem_fill.sv
// Self-checking bench for vmem_fill: directed and random fills compared against a
// row-major rectangle model with screen clipping.
module tb_vmem_fill;
    import vmem_fill_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        cpu_we_i = 1'b0;
    logic [15:0] cpu_addr_i = '0;
    logic [2:0]  cpu_wdata_i = '0;
    logic        vmem_we_o;
    logic [15:0] vmem_addr_o;
    logic [2:0]  vmem_wdata_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    logic [18:0] got_q[$];
    logic [18:0] exp_q[$];
    int busy_cnt = 0;

    vmem_fill #(
        .SCREEN_W (240),
        .SCREEN_H (240)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .vmem_we_o    (vmem_we_o),
        .vmem_addr_o  (vmem_addr_o),
        .vmem_wdata_o (vmem_wdata_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Engine writes are those that appear when the CPU is not storing.
    always @(negedge clk) begin
        if (rst_n && !cpu_we_i && vmem_we_o) got_q.push_back({vmem_addr_o, vmem_wdata_o});
        if (busy_o) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        we_i = 1'b1;
        addr_i = a;
        wdata_i = d;
        tick();
        we_i = 1'b0;
        wdata_i = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        addr_i = a;
        tick();
        d = rdata_o;
    endtask

    // Expected engine writes: every pixel of the rectangle in row-major order,
    // minus those off the 240x240 screen.
    task automatic build_exp(input int x0, input int y0, input int w, input int h, input int c);
        exp_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                int x, y;
                x = x0 + k;
                y = y0 + r;
                if (x < 240 && y < 240) exp_q.push_back({8'(y), 8'(x), 3'(c)});
            end
        end
    endtask

    task automatic start_fill(input int x0, input int y0, input int w, input int h, input int c);
        bus_write(REG_ORG, {16'b0, 8'(y0), 8'(x0)});
        bus_write(REG_SIZE, {16'b0, 8'(h), 8'(w)});
        bus_write(REG_COLOR, 32'(c & 7));
        build_exp(x0, y0, w, h, c & 7);
        got_q.delete();
        busy_cnt = 0;
        bus_write(REG_CTRL, 32'h1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (busy_o) begin
            errors++;
            $display("FAIL %s timeout: busy still %0d after %0d cycles, required 0", name, busy_o, n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        cpu_we_i = 1'b1;
        cpu_addr_i = 16'h1234;
        cpu_wdata_i = 3'd3;
        #3;
        checks++;
        if ({vmem_we_o, vmem_addr_o, vmem_wdata_o} !== {1'b1, 16'h1234, 3'd3}) begin
            errors++;
            $display("FAIL reset_passthru: got %0b/%h/%0d required 1/1234/3",
                     vmem_we_o, vmem_addr_o, vmem_wdata_o);
        end
        checks++;
        if (busy_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy %0b rdata %h required 0 and 0", busy_o, rdata_o);
        end
        cpu_we_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(i * 4), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h required 0", i * 4, d);
            end
        end
    endtask

    task automatic test_fill(input int x0, input int y0, input int w, input int h, input int c,
                             input string name);
        logic [31:0] d;
        start_fill(x0, y0, w, h, c);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s start_busy: got %0b required 1", name, busy_o);
        end
        wait_idle(name);
        checks++;
        if (busy_cnt != w * h) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, w * h);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d required %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s pixel%0d: got addr %h data %0d required addr %h data %0d",
                             name, i, got_q[i][18:3], got_q[i][2:0], exp_q[i][18:3], exp_q[i][2:0]);
                end
            end
        end
        bus_read(REG_CTRL, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL %s ctrl_done: got %h required 4", name, d);
        end
        bus_write(REG_CTRL, 32'h4);
        bus_read(REG_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL %s clr_done: got %h required 0", name, d);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        bus_write(REG_ORG, 32'hABCD_0A05);
        bus_write(REG_SIZE, 32'h1234_0302);
        bus_write(REG_COLOR, 32'hFFFF_FFFD);
        bus_read(REG_ORG, d);
        checks++;
        if (d !== 32'h0A05) begin
            errors++;
            $display("FAIL regs_org: got %h required 00000a05", d);
        end
        bus_read(REG_SIZE, d);
        checks++;
        if (d !== 32'h0302) begin
            errors++;
            $display("FAIL regs_size: got %h required 00000302", d);
        end
        bus_read(REG_COLOR, d);
        checks++;
        if (d !== 32'h5) begin
            errors++;
            $display("FAIL regs_color: got %h required 5", d);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        start_fill(10, 20, 4, 2, 3);
        for (int s = 0; s < 2; s++) begin
            tick();
            cpu_we_i = 1'b1;
            cpu_addr_i = 16'($urandom);
            cpu_wdata_i = 3'($urandom);
            @(negedge clk);
            checks++;
            if ({vmem_we_o, vmem_addr_o, vmem_wdata_o} !== {1'b1, cpu_addr_i, cpu_wdata_i}) begin
                errors++;
                $display("FAIL stall_cpu%0d: got %0b/%h/%0d required 1/%h/%0d", s, vmem_we_o,
                         vmem_addr_o, vmem_wdata_o, cpu_addr_i, cpu_wdata_i);
            end
        end
        tick();
        cpu_we_i = 1'b0;
        // Parameter writes while busy must be dropped.
        bus_write(REG_ORG, 32'hFFFF);
        bus_write(REG_SIZE, 32'h0);
        wait_idle("stall");
        checks++;
        if (busy_cnt != 10) begin
            errors++;
            $display("FAIL stall_busy_cycles: got %0d required 10", busy_cnt);
        end
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL stall_pixels: got %0d strobes required %0d (or contents differ)",
                     got_q.size(), exp_q.size());
        end
        bus_read(REG_ORG, d);
        checks++;
        if (d !== 32'h140A) begin
            errors++;
            $display("FAIL stall_org_locked: got %h required 0000140a", d);
        end
        bus_write(REG_CTRL, 32'h4);
    endtask

    task automatic test_empty(input int w, input int h);
        logic [31:0] d;
        bus_write(REG_SIZE, {16'b0, 8'(h), 8'(w)});
        got_q.delete();
        busy_cnt = 0;
        bus_write(REG_CTRL, 32'h1);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_busy w%0d h%0d: got %0b required 0", w, h, busy_o);
        end
        bus_read(REG_CTRL, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL empty_done w%0d h%0d: got %h required 4", w, h, d);
        end
        tick();
        checks++;
        if (got_q.size() != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL empty_activity w%0d h%0d: strobes %0d busy %0d required 0 0",
                     w, h, got_q.size(), busy_cnt);
        end
        bus_write(REG_CTRL, 32'h4);
    endtask

    task automatic test_abort();
        logic [31:0] d;
        start_fill(0, 0, 10, 10, 6);
        tick();
        tick();
        we_i = 1'b1;
        addr_i = REG_CTRL;
        wdata_i = 32'h3;
        tick();
        we_i = 1'b0;
        wdata_i = '0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %0b required 0", busy_o);
        end
        tick();
        tick();
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL abort_strobes: got %0d required 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL abort_pixel%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        bus_read(REG_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL abort_done: got %h required 0", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int n;
        start_fill(10, 10, 20, 5, 2);
        for (int i = 0; i < 5; i++) tick();
        addr_i = REG_CTRL;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || vmem_we_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: busy %0b we %0b rdata %h required 0 0 0",
                     busy_o, vmem_we_o, rdata_o);
        end
        n = got_q.size();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL rstmid_no_strobe: got %0d strobes required %0d", got_q.size(), n);
        end
        bus_read(REG_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_ctrl: got %h required 0", d);
        end
        test_fill(30, 40, 7, 3, 4, "after_reset");
    endtask

    initial begin
        test_reset();
        test_regs();
        test_fill(5, 10, 2, 3, 5, "basic");
        test_fill(238, 0, 4, 1, 6, "clip_x");
        test_fill(100, 237, 3, 5, 1, "clip_y");
        test_fill(250, 250, 3, 2, 7, "offscreen");
        for (int i = 0; i < 6; i++) begin
            test_fill(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(1, 24)), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 7)), "random");
        end
        test_stall();
        test_empty(0, 3);
        test_empty(5, 0);
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
